cmd_rx: RTL
===========

Name: cmd_rx

Overview:
Command deframer that sits upstream of cmd_tx. It consumes the host byte stream arriving over a valid/ready interface and parses 6-byte command frames. Each complete, valid frame is presented as one memory request (mreq) on the same handshake and field set that cmd_tx takes. Malformed frames and stalled partial frames are dropped and reported.

Parameters:
TIMEOUT_CYCLES, 1000, inter-byte timeout within a partial frame; 0 disables the timeout
ERRCNT_W, 8, width of the saturating error counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  incoming byte
i_rx_valid  in  1  byte valid
o_rx_ready  out  1  byte accepted when valid&&ready
o_mreq_valid  out  1  request valid
i_mreq_ready  in  1  downstream accepts request
o_mreq_wr  out  1  1=write, 0=read
o_mreq_wsize  out  2  word size (cmd_defines.vh: 0=1B, 1=2B, 2=4B, 3 reserved)
o_mreq_aincr  out  1  address auto-increment
o_mreq_wcount  out  8  word count
o_mreq_addr  out  32  start address
o_err  out  1  one-cycle error pulse
o_err_code  out  2  1=bad sync, 2=bad wsize, 3=timeout; valid only with o_err
o_err_count  out  ERRCNT_W  saturating error count

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n. On reset assertion, all state clears immediately; any partial frame or pending request is lost.
- Reset values: o_mreq_valid=0, all mreq fields=0, o_err=0, o_err_code=0, o_err_count=0. State=HDR, so o_rx_ready=1 after reset releases.
- Frame layout, in byte order:
  - byte0 header = {4'hA sync[7:4], wr[3], aincr[2], wsize[1:0]}
  - byte1 = wcount
  - bytes2..5 = addr, MSB first
- FSM states: HDR, CNT, ADDR (2-bit byte index 0..3), OUT. o_rx_ready=1 in HDR/CNT/ADDR and 0 in OUT.
- HDR on accepted byte:
  - If sync!=4'hA: drop the byte, pulse o_err with code 1, stay in HDR. This is byte-wise resync.
  - Else if wsize==3: drop, pulse o_err with code 2, stay in HDR.
  - Else: latch wr/aincr/wsize and go to CNT.
- CNT on accepted byte: latch wcount, index=0, go to ADDR.
- ADDR on accepted byte: shift the byte into addr (addr <= {addr[23:0], byte}).
  - On index 3, go to OUT and assert o_mreq_valid on the next edge.
  - Latency: o_mreq_valid is high on the first cycle after the last-byte handshake.
- OUT: o_mreq_valid and all fields stay stable until i_mreq_ready is high at a clock edge. Then o_mreq_valid=0 and state returns to HDR, so o_rx_ready=1 on the following cycle.
- mreq fields are only updated in HDR/CNT/ADDR. They hold their last values after the handshake.
- wcount=0 is passed through unmodified; interpretation belongs to downstream.
- Timeout, in CNT or ADDR only:
  - The counter clears on every accepted byte and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES: discard the partial frame, pulse o_err with code 3, go to HDR.
  - If a byte is accepted on the same cycle the limit is reached, the byte wins and no timeout occurs.
  - There is no timeout in HDR or OUT. With TIMEOUT_CYCLES=0 the counter is never checked.
- o_err_count increments on every o_err pulse and saturates at all-ones.
- i_rx_valid may drop mid-frame without penalty, short of timeout. Bytes are never accepted while o_rx_ready=0.

Test Plan:
- Send A5 05 12 34 56 78 with i_mreq_ready=1 -> o_mreq_valid high one cycle after the 0x78 handshake: wr=0, aincr=1, wsize=1, wcount=5, addr=0x12345678. o_rx_ready=1 two cycles after the 0x78 handshake; no o_err.
- Send AD 05 43 21 12 34 with i_mreq_ready=0 for 10 cycles -> request held stable and o_rx_ready=0 for all 10 cycles. It completes with wr=1, addr=0x43211234 when i_mreq_ready rises.
- Send 55 then A5 05 12 34 56 78 -> single o_err with code 1, o_err_count=1, then the correct request as in scenario 1.
- Send A7 (wsize=3) -> o_err with code 2, state HDR, no request.
- With TIMEOUT_CYCLES=20: send A5 05 12, then idle 25 cycles -> o_err with code 3 exactly 20 cycles after the 0x12 handshake. A following full frame decodes correctly.
- Assert i_rst_n=0 mid-ADDR, then complete the old frame's bytes after release -> no request. Bad-sync errors are counted for any non-0xA? bytes seen in HDR.

Source files
------------

// File: rtl/cmd_rx.sv
// cmd_rx: host byte-stream deframer, 6-byte command frames -> one mreq.
// Ports: i_rx_* byte in, o_mreq_*/i_mreq_ready request out, o_err_* status.
module cmd_rx #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ERRCNT_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic                o_mreq_valid,
  input  logic                i_mreq_ready,
  output logic                o_mreq_wr,
  output logic [1:0]          o_mreq_wsize,
  output logic                o_mreq_aincr,
  output logic [7:0]          o_mreq_wcount,
  output logic [31:0]         o_mreq_addr,
  output logic                o_err,
  output logic [1:0]          o_err_code,
  output logic [ERRCNT_W-1:0] o_err_count
);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_CNT  = 2'd1;
  localparam logic [1:0] S_ADDR = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [1:0] E_SYNC = 2'd1;
  localparam logic [1:0] E_WSZ  = 2'd2;
  localparam logic [1:0] E_TMO  = 2'd3;

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Fire on the cycle the idle count would reach the limit.
  localparam logic [TW-1:0] TLIM =
    TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;

  logic          accept;
  logic          in_frame;
  logic          hdr_acc;
  logic          hdr_sync;
  logic          hdr_wsz;
  logic          tmo_hit;
  logic          err_hit;
  logic [1:0]    err_nxt;

  assign o_rx_ready = (state != S_OUT);
  assign accept     = i_rx_valid && o_rx_ready;
  assign in_frame   = (state == S_CNT) || (state == S_ADDR);
  assign hdr_acc    = accept && (state == S_HDR);
  assign hdr_sync   = hdr_acc && (i_rx_data[7:4] != 4'hA);
  assign hdr_wsz    = hdr_acc && (i_rx_data[7:4] == 4'hA)
                      && (i_rx_data[1:0] == 2'b11);
  // An accepted byte beats an expiring timer.
  assign tmo_hit    = TMO_EN && in_frame && !accept
                      && (tcnt == TLIM);

  always_comb begin
    err_hit = 1'b0;
    err_nxt = 2'b00;
    unique case (1'b1)
      hdr_sync: begin
        err_hit = 1'b1;
        err_nxt = E_SYNC;
      end
      hdr_wsz: begin
        err_hit = 1'b1;
        err_nxt = E_WSZ;
      end
      tmo_hit: begin
        err_hit = 1'b1;
        err_nxt = E_TMO;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_HDR;
      idx           <= 2'd0;
      tcnt          <= '0;
      o_mreq_valid  <= 1'b0;
      o_mreq_wr     <= 1'b0;
      o_mreq_wsize  <= 2'd0;
      o_mreq_aincr  <= 1'b0;
      o_mreq_wcount <= 8'd0;
      o_mreq_addr   <= 32'd0;
    end else begin
      case (state)
        S_HDR: begin
          if (hdr_acc && !err_hit) begin
            o_mreq_wr    <= i_rx_data[3];
            o_mreq_aincr <= i_rx_data[2];
            o_mreq_wsize <= i_rx_data[1:0];
            state        <= S_CNT;
          end
        end
        S_CNT: begin
          if (accept) begin
            o_mreq_wcount <= i_rx_data;
            idx           <= 2'd0;
            state         <= S_ADDR;
          end else if (tmo_hit) begin
            state <= S_HDR;
          end
        end
        S_ADDR: begin
          if (accept) begin
            o_mreq_addr <= {o_mreq_addr[23:0], i_rx_data};
            idx         <= idx + 2'd1;
            if (idx == 2'd3) begin
              state        <= S_OUT;
              o_mreq_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            state <= S_HDR;
          end
        end
        default: begin
          if (i_mreq_ready) begin
            o_mreq_valid <= 1'b0;
            state        <= S_HDR;
          end
        end
      endcase

      if (accept || !in_frame || tmo_hit) begin
        tcnt <= '0;
      end else if (TMO_EN) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err       <= 1'b0;
      o_err_code  <= 2'd0;
      o_err_count <= '0;
    end else begin
      o_err      <= err_hit;
      o_err_code <= err_nxt;
      if (err_hit && (o_err_count != '1)) begin
        o_err_count <= o_err_count + ERRCNT_W'(1);
      end
    end
  end

endmodule
